mem_access_unit: RTL and testbench

- Memory-stage access unit directly downstream of the core's M stage.
- Consumes the core's ALUOutM / writeDataM / memWriteM / memRead strobes and drives an SRAM-like request/response data bus.
- Returns aligned, extended load data as readDataM.
- Generates a pipeline stall while the bus transaction is outstanding and flags misaligned accesses instead of issuing them.

---
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// SRAM-like request/response bus between mem_access_unit (master) and memory (slave).
// Request: bus_req is valid, bus_addr_ok is ready; one request transfers when both are 1.
// Response: bus_data_ok marks bus_rdata valid (or acknowledges a write) for that cycle;
// the master is always ready.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_wr;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wstrb;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_err;

    modport master (
        output bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata, bus_err,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata, bus_err,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns M-stage load/store strobes into bus transactions.
// Optional MEM_TIMEOUT_EN adds a WAIT_DATA timeout that pulses bus_err.
module mem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [1:0]        mem_size,
    input  logic              load_sign,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              adel,
    output logic              ades,
    output logic [1:0]        dbgState,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        DONE      = 2'd2
    } state_t;

    state_t state, stateNext;

    logic        req, isStore, misaligned, goReq;
    logic [1:0]  lane;
    logic        busReqC, stallC, capture, timeoutHit, expire;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [DATA_W-1:0] loadData, storeData;
    logic [3:0]  storeStrb;

    assign req        = mem_read | mem_write;
    assign isStore    = mem_write;
    assign lane       = mem_addr[1:0];
    assign misaligned = ((mem_size == 2'd1) && lane[0]) ||
                        (mem_size[1] && (lane != 2'b00));
    assign goReq      = req && !misaligned;

    assign loadByte = bus.bus_rdata[{lane, 3'b000} +: 8];
    assign loadHalf = lane[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

    always_comb begin
        loadData  = bus.bus_rdata;
        storeData = mem_wdata;
        storeStrb = 4'b1111;
        case (mem_size)
            2'd0: begin
                loadData  = {{24{load_sign & loadByte[7]}}, loadByte};
                storeData = {4{mem_wdata[7:0]}};
                storeStrb = 4'b0001 << lane;
            end
            2'd1: begin
                loadData  = {{16{load_sign & loadHalf[15]}}, loadHalf};
                storeData = {2{mem_wdata[15:0]}};
                storeStrb = 4'b0011 << lane;
            end
            default: ;
        endcase
    end

    always_comb begin
        stateNext  = state;
        busReqC    = 1'b0;
        stallC     = 1'b0;
        capture    = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (goReq) begin
                    busReqC = 1'b1;
                    stallC  = 1'b1;
                    if (bus.bus_addr_ok) begin
                        if (bus.bus_data_ok) begin
                            capture   = 1'b1;
                            stateNext = DONE;
                        end else begin
                            stateNext = WAIT_DATA;
                        end
                    end
                end
            end
            WAIT_DATA: begin
                stallC = 1'b1;
                if (bus.bus_data_ok) begin
                    capture   = 1'b1;
                    stateNext = DONE;
                end else if (expire) begin
                    timeoutHit = 1'b1;
                    stateNext  = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            read_data <= '0;
        end else begin
            state <= stateNext;
            if (timeoutHit)
                read_data <= '0;
            else if (capture && !isStore)
                read_data <= loadData;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
    logic [CNT_W-1:0] waitCnt;
    logic             busErrQ;

    // Counter is cleared while idle, so it starts at zero on every WAIT_DATA entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt <= '0;
            busErrQ <= 1'b0;
        end else begin
            busErrQ <= timeoutHit;
            if (state == WAIT_DATA)
                waitCnt <= waitCnt + CNT_W'(1);
            else
                waitCnt <= '0;
        end
    end

    assign expire      = (state == WAIT_DATA) && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.bus_err = busErrQ;
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT_CYCLES != 0);
    assign expire        = 1'b0;
    assign bus.bus_err   = 1'b0;
`endif

    // Reset gates the combinational outputs so the bus goes quiet the moment rst falls.
    assign stall         = rst & stallC;
    assign bus.bus_req   = rst & busReqC;
    assign bus.bus_wr    = rst & busReqC & isStore;
    assign bus.bus_addr  = bus.bus_req ? {mem_addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus.bus_wstrb = bus.bus_wr ? storeStrb : 4'b0000;
    assign bus.bus_wdata = bus.bus_wr ? storeData : '0;
    assign adel          = rst && (state == IDLE) && req && !isStore && misaligned;
    assign ades          = rst && (state == IDLE) && isStore && misaligned;
    assign dbgState      = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a byte-lane reference model.
// Define MEM_TIMEOUT_EN for both files to include the timeout scenario.
module tb_mem_access_unit;

    localparam int TB_TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, load_sign = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [1:0]  mem_size = '0;
    logic [31:0] read_data;
    logic        stall, adel, ades;
    logic [1:0]  dbgState;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expRd  = '0;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .load_sign(load_sign),
        .read_data(read_data), .stall(stall),
        .adel(adel), .ades(ades), .dbgState(dbgState),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: an access covers n consecutive byte lanes starting at addr%4.
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_misaligned(input logic [31:0] addr, input logic [1:0] size);
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [31:0] addr, input logic [1:0] size);
        logic [3:0] s = '0;
        int a = addr % 4;
        for (int k = 0; k < 4; k++)
            if (k >= a && k < a + nbytes(size)) s[k] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] size);
        logic [31:0] v = '0;
        int n = nbytes(size);
        for (int k = 0; k < 4; k++) v[8*k +: 8] = wd[8*(k % n) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] addr,
                                           input logic [1:0] size, input logic sgn);
        logic [31:0] v = '0;
        int n = nbytes(size);
        int a = addr % 4;
        for (int k = 0; k < n; k++) v[8*k +: 8] = rd[8*(a+k) +: 8];
        if (n < 4 && sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    // Called just after a rising edge; returns just after a rising edge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] size, input logic sgn,
                          input int addrWait, input int dataWait, input logic [31:0] rdata);
        int stallCnt = 0;
        logic [31:0] expAddr = {addr[31:2], 2'b00};
        logic [3:0]  expStrb = wr ? m_strb(addr, size) : 4'b0000;
        logic [31:0] expWd   = wr ? m_wdata(wd, size) : 32'h0;
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd;
        mem_size = size; load_sign = sgn;
        for (int i = 0; i <= addrWait; i++) begin
            bus.bus_addr_ok = (i == addrWait);
            bus.bus_data_ok = (i == addrWait) && (dataWait == 0);
            bus.bus_rdata   = bus.bus_data_ok ? rdata : $urandom;
            @(negedge clk);
            check("req_valid", {31'b0, bus.bus_req}, 32'd1);
            check("req_addr", bus.bus_addr, expAddr);
            check("req_wr", {31'b0, bus.bus_wr}, {31'b0, wr});
            check("req_wstrb", {28'b0, bus.bus_wstrb}, {28'b0, expStrb});
            check("req_wdata", bus.bus_wdata, expWd);
            if (stall) stallCnt++;
            @(posedge clk); #1;
        end
        for (int j = 1; j <= dataWait; j++) begin
            bus.bus_addr_ok = 1'b0;
            bus.bus_data_ok = (j == dataWait);
            bus.bus_rdata   = bus.bus_data_ok ? rdata : $urandom;
            @(negedge clk);
            check("wait_req", {31'b0, bus.bus_req}, 32'd0);
            if (stall) stallCnt++;
            @(posedge clk); #1;
        end
        bus.bus_addr_ok = 1'b0;
        bus.bus_data_ok = 1'b0;
        if (!wr) expRd = m_load(rdata, addr, size, sgn);
        @(negedge clk);
        check("done_stall", {31'b0, stall}, 32'd0);
        check("done_req", {31'b0, bus.bus_req}, 32'd0);
        check("stall_cycles", stallCnt, addrWait + 1 + dataWait);
        check("read_data", read_data, expRd);
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic misalign(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [1:0] size);
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_size = size;
        mem_wdata = $urandom;
        bus.bus_addr_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("adel", {31'b0, adel}, {31'b0, !wr});
            check("ades", {31'b0, ades}, {31'b0, wr});
            check("mis_req", {31'b0, bus.bus_req}, 32'd0);
            check("mis_stall", {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0; bus.bus_addr_ok = 1'b0;
        @(negedge clk);
        check("mis_rd_keep", read_data, expRd);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.bus_addr_ok = 1'b0;
        bus.bus_data_ok = 1'b0;
        bus.bus_rdata   = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read_data", read_data, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_req", {31'b0, bus.bus_req}, 32'd0);
        check("rst_addr", bus.bus_addr, 32'h0);
        check("rst_err", {31'b0, bus.bus_err}, 32'd0);
        check("rst_adel", {30'b0, adel, ades}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed accesses
        access(1, 0, 32'h100, 32'h0, 2'd2, 0, 0, 1, 32'hDEAD_BEEF);
        check("lw_value", read_data, 32'hDEAD_BEEF);
        access(1, 0, 32'h103, 32'h0, 2'd0, 1, 0, 1, 32'h8012_3456);
        check("lb_value", read_data, 32'hFFFF_FF80);
        access(1, 0, 32'h103, 32'h0, 2'd0, 0, 0, 1, 32'h8012_3456);
        check("lbu_value", read_data, 32'h0000_0080);
        access(0, 1, 32'h102, 32'h0000_ABCD, 2'd1, 0, 0, 1, 32'h0);
        misalign(1, 0, 32'h101, 2'd2);
        misalign(0, 1, 32'h001, 2'd1);
        access(1, 0, 32'h204, 32'h0, 2'd1, 1, 3, 0, 32'h1234_F00D);
        access(1, 1, 32'h308, 32'h5566_7788, 2'd3, 0, 1, 2, 32'hFFFF_FFFF);

        // Reset in WAIT_DATA, then a late data_ok
        mem_read = 1'b1; mem_addr = 32'h400; mem_size = 2'd2;
        bus.bus_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.bus_addr_ok = 1'b0;
        @(negedge clk);
        check("wait_stall", {31'b0, stall}, 32'd1);
        #1 rst = 1'b0;
        expRd = 32'h0;
        #1;
        check("mid_rst_req", {31'b0, bus.bus_req}, 32'd0);
        check("mid_rst_stall", {31'b0, stall}, 32'd0);
        check("mid_rst_rd", read_data, 32'h0);
        check("mid_rst_err", {31'b0, bus.bus_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b0;
        bus.bus_data_ok = 1'b1; bus.bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("late_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        bus.bus_data_ok = 1'b0;
        @(negedge clk);
        check("late_rd", read_data, 32'h0);
        check("late_req", {31'b0, bus.bus_req}, 32'd0);
        @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
        // No data_ok: TB_TO WAIT_DATA cycles, then an error pulse in DONE
        access(1, 0, 32'h500, 32'h0, 2'd2, 0, 0, 1, 32'h1111_2222);
        mem_read = 1'b1; mem_addr = 32'h600; mem_size = 2'd2;
        bus.bus_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.bus_addr_ok = 1'b0;
        for (int i = 0; i < TB_TO; i++) begin
            @(negedge clk);
            check("to_stall", {31'b0, stall}, 32'd1);
            check("to_err_low", {31'b0, bus.bus_err}, 32'd0);
            @(posedge clk); #1;
        end
        mem_read = 1'b0;
        expRd = 32'h0;
        @(negedge clk);
        check("to_err_pulse", {31'b0, bus.bus_err}, 32'd1);
        check("to_rd_zero", read_data, 32'h0);
        check("to_done_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("to_err_clear", {31'b0, bus.bus_err}, 32'd0);
        @(posedge clk); #1;
`endif

        // Randomized accesses
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a = $urandom;
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            int          kind = $urandom_range(1, 3);
            logic        rd = (kind != 2);
            logic        wr = (kind != 1);
            if (m_misaligned(a, sz))
                misalign(rd, wr, a, sz);
            else
                access(rd, wr, a, $urandom, sz, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
